// File: rtl/mat_mul_stream.sv
// Streaming DIMxDIM signed matrix multiplier: loads A/B over s00_axis, computes R = A x B, streams R on m00_axis.
// Optional macro MAT_MUL_SAT_EN clamps each result element to the DATA_WIDTH signed range instead of wrapping.
module mat_mul_stream #(
   parameter int DIM_LOG    = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   output logic                    s00_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                    s00_axis_tlast,
   input  logic                    s00_axis_tvalid,
   output logic                    m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready,
   input  logic                    sel,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   localparam int DIM       = 2 ** DIM_LOG;
   localparam int SIZE      = DIM * DIM;
   localparam int SIZE_LOG  = 2 * DIM_LOG;
   localparam int ACC_WIDTH = 2 * DATA_WIDTH + DIM_LOG;
   localparam int IDX_W     = 3 * DIM_LOG;
   localparam int CNT_W     = IDX_W + 1;
   localparam logic [SIZE_LOG-1:0] LAST_IDX  = SIZE_LOG'(SIZE - 1);
   localparam logic [CNT_W-1:0]    CALC_LAST = CNT_W'(DIM * SIZE + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_CALC, S_OUTPUT} state_t;

   state_t                        state;
   logic                          a_valid;
   logic [SIZE_LOG-1:0]           ld_cnt;
   logic [CNT_W-1:0]              calc_cnt;
   logic [SIZE_LOG-1:0]           out_cnt;
   logic [SIZE_LOG-1:0]           out_nxt;
   logic                          out_primed;

   logic [DATA_WIDTH-1:0]         a_mem [SIZE];
   logic [DATA_WIDTH-1:0]         b_mem [SIZE];
   logic [DATA_WIDTH-1:0]         r_mem [SIZE];

   logic signed [DATA_WIDTH-1:0]   a_rd, b_rd;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    prod_ext, acc, acc_base, acc_next;
   logic [DATA_WIDTH-1:0]          r_store;

   logic                 beat, a_we, b_we, acc_en;
   logic [IDX_W-1:0]     iss_idx, acc_idx;
   logic [DIM_LOG-1:0]   acc_k;
   logic [SIZE_LOG-1:0]  acc_elem, a_addr, b_addr;

   assign m00_axis_tstrb = '1;
   assign beat    = s00_axis_tvalid & s00_axis_tready;
   assign a_we    = s00_axi_aresetn & beat & (state == S_LOAD_A);
   assign b_we    = s00_axi_aresetn & beat & (state == S_LOAD_B);
   assign out_nxt = out_cnt + 1'b1;

   // Issue index = {i, j, k}; the accumulate stage trails it by the read and multiply registers.
   assign iss_idx  = calc_cnt[IDX_W-1:0];
   assign a_addr   = {iss_idx[IDX_W-1:SIZE_LOG], iss_idx[DIM_LOG-1:0]};
   assign b_addr   = {iss_idx[DIM_LOG-1:0], iss_idx[SIZE_LOG-1:DIM_LOG]};
   assign acc_idx  = iss_idx - IDX_W'(2);
   assign acc_k    = acc_idx[DIM_LOG-1:0];
   assign acc_elem = acc_idx[IDX_W-1:DIM_LOG];
   assign acc_en   = s00_axi_aresetn & (state == S_CALC) & (calc_cnt >= CNT_W'(2));
   assign prod_ext = {{DIM_LOG{prod[2*DATA_WIDTH-1]}}, prod};

`ifdef MAT_MUL_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

   always_comb begin
      acc_base = (acc_k == '0) ? '0 : acc;
      acc_next = acc_base + prod_ext;
`ifdef MAT_MUL_SAT_EN
      if (acc_next > SAT_MAX)
         r_store = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (acc_next < SAT_MIN)
         r_store = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         r_store = acc_next[DATA_WIDTH-1:0];
`else
      r_store = acc_next[DATA_WIDTH-1:0];
`endif
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (a_we) a_mem[ld_cnt] <= s00_axis_tdata;
      if (b_we) b_mem[ld_cnt] <= s00_axis_tdata;
      a_rd <= a_mem[a_addr];
      b_rd <= b_mem[b_addr];
      prod <= a_rd * b_rd;
      if (acc_en) begin
         acc <= acc_next;
         if (&acc_k) r_mem[acc_elem] <= r_store;
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         state           <= S_IDLE;
         a_valid         <= 1'b0;
         ld_cnt          <= '0;
         calc_cnt        <= '0;
         out_cnt         <= '0;
         out_primed      <= 1'b0;
         s00_axis_tready <= 1'b0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tdata  <= '0;
         m00_axis_tlast  <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  err             <= 1'b0;
                  busy            <= 1'b1;
                  s00_axis_tready <= 1'b1;
                  ld_cnt          <= '0;
                  state           <= (sel && a_valid) ? S_LOAD_B : S_LOAD_A;
               end
            end
            S_LOAD_A, S_LOAD_B: begin
               if (beat) begin
                  // Framing is judged against the beat count; tlast never alters the load length.
                  if ((ld_cnt == LAST_IDX) != s00_axis_tlast) err <= 1'b1;
                  if (ld_cnt == LAST_IDX) begin
                     ld_cnt <= '0;
                     if (state == S_LOAD_A) begin
                        a_valid <= 1'b1;
                        state   <= S_LOAD_B;
                     end else begin
                        s00_axis_tready <= 1'b0;
                        calc_cnt        <= '0;
                        state           <= S_CALC;
                     end
                  end else begin
                     ld_cnt <= ld_cnt + 1'b1;
                  end
               end
            end
            S_CALC: begin
               if (calc_cnt == CALC_LAST) begin
                  out_cnt    <= '0;
                  out_primed <= 1'b0;
                  state      <= S_OUTPUT;
               end else begin
                  calc_cnt <= calc_cnt + 1'b1;
               end
            end
            S_OUTPUT: begin
               // First cycle prefetches R[0]; afterwards each handshake loads the next element.
               if (!out_primed) begin
                  out_primed      <= 1'b1;
                  m00_axis_tdata  <= r_mem[0];
                  m00_axis_tvalid <= 1'b1;
                  m00_axis_tlast  <= (SIZE == 1);
               end else if (m00_axis_tready) begin
                  if (out_cnt == LAST_IDX) begin
                     m00_axis_tvalid <= 1'b0;
                     m00_axis_tlast  <= 1'b0;
                     done            <= 1'b1;
                     busy            <= 1'b0;
                     state           <= S_IDLE;
                  end else begin
                     out_cnt        <= out_nxt;
                     m00_axis_tdata <= r_mem[out_nxt];
                     m00_axis_tlast <= (out_nxt == LAST_IDX);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
